// File: rtl/prbs7_checker.sv
// Serial PRBS7 (x^7+x^6+1, XNOR form) checker with seed/verify/lock tracking.
// Define PRBS7_ERR_CNT_EN to build the saturating error counter; otherwise err_cnt is tied to 0.
module prbs7_checker #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       d,
    input  logic       clr,
    output logic       lock,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [6:0]    sr, sr_nxt;
    logic [2:0]    seed_cnt, seed_cnt_nxt;
    logic [MW-1:0] match_cnt, match_cnt_nxt;
    logic [LW-1:0] miss_cnt, miss_cnt_nxt;
    logic          pred;
    logic          mismatch;
    logic          err_nxt;
    logic          count_err;

    assign pred     = ~(sr[6] ^ sr[5]);
    assign mismatch = d ^ pred;

    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt     = state;
        sr_nxt        = sr;
        seed_cnt_nxt  = seed_cnt;
        match_cnt_nxt = match_cnt;
        miss_cnt_nxt  = miss_cnt;
        err_nxt       = 1'b0;
        count_err     = 1'b0;

        if (en) begin
            unique case (state)
                SEED: begin
                    sr_nxt = {sr[5:0], d};
                    if (seed_cnt == 3'd6) begin
                        seed_cnt_nxt = 3'd0;
                        // An all-ones register is the XNOR lockup state; keep seeding.
                        if ({sr[5:0], d} != 7'h7F) begin
                            state_nxt     = VERIFY;
                            match_cnt_nxt = '0;
                        end
                    end else begin
                        seed_cnt_nxt = seed_cnt + 3'd1;
                    end
                end

                VERIFY: begin
                    sr_nxt = {sr[5:0], pred};
                    if (mismatch) begin
                        state_nxt     = SEED;
                        seed_cnt_nxt  = 3'd0;
                        match_cnt_nxt = '0;
                    end else if (match_cnt == MATCH_LAST) begin
                        state_nxt     = LOCKED;
                        match_cnt_nxt = '0;
                        miss_cnt_nxt  = '0;
                    end else begin
                        match_cnt_nxt = match_cnt + 1'b1;
                    end
                end

                LOCKED: begin
                    // Reference free-runs so one flipped bit costs exactly one error.
                    sr_nxt = {sr[5:0], pred};
                    if (mismatch) begin
                        err_nxt   = 1'b1;
                        count_err = 1'b1;
                        if (miss_cnt == MISS_LAST) begin
                            state_nxt    = SEED;
                            seed_cnt_nxt = 3'd0;
                            miss_cnt_nxt = '0;
                        end else begin
                            miss_cnt_nxt = miss_cnt + 1'b1;
                        end
                    end else begin
                        miss_cnt_nxt = '0;
                    end
                end

                default: begin
                    state_nxt    = SEED;
                    seed_cnt_nxt = 3'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEED;
            sr        <= 7'h00;
            seed_cnt  <= 3'd0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            lock      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            seed_cnt  <= seed_cnt_nxt;
            match_cnt <= match_cnt_nxt;
            miss_cnt  <= miss_cnt_nxt;
            lock      <= (state_nxt == LOCKED);
            err       <= err_nxt;
        end
    end

`ifdef PRBS7_ERR_CNT_EN
    logic [7:0] cnt_base;

    // Clear takes effect before a same-cycle increment, so clr plus an error yields 1.
    assign cnt_base = clr ? 8'h00 : err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (count_err) begin
            err_cnt <= (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'h01;
        end else if (clr) begin
            err_cnt <= 8'h00;
        end
    end
`else
    logic unused_clr;

    assign unused_clr = clr ^ count_err;
    assign err_cnt    = 8'h00;
`endif

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: expectations queued per driven bit and compared after each edge.
// Expected err_cnt follows PRBS7_ERR_CNT_EN (counted value when defined, 0 otherwise).
module tb_prbs7_checker;

    logic       clk;
    logic       rst;
    logic       en;
    logic       d;
    logic       clr;
    logic       lock;
    logic       err;
    logic [7:0] err_cnt;

    typedef struct packed {
        logic       lock;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp;
    int         n_mis;
    int         mm;     // counted mismatches since last clear/reset
    int         run;    // accepted clean bits since fresh seed
    logic [6:0] g;      // reference PRBS7 generator

    prbs7_checker #(.LOCK_CNT(8), .LOSS_CNT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .d       (d),
        .clr     (clr),
        .lock    (lock),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xc(input int v);
`ifdef PRBS7_ERR_CNT_EN
        xc = (v > 255) ? 8'hFF : 8'(v);
`else
        xc = 8'h00;
`endif
    endfunction

    function automatic exp_t mk(input logic l, input logic e, input logic [7:0] c);
        exp_t t;
        t.lock = l;
        t.err  = e;
        t.cnt  = c;
        return t;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic gen_bit(output logic b);
        b = ~(g[6] ^ g[5]);
        g = {g[5:0], b};
    endtask

    task automatic step(input logic e, input logic dv, input logic c, input exp_t x, input string tag);
        exp_t got;
        @(negedge clk);
        en  = e;
        d   = dv;
        clr = c;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, " lock"}, {7'b0, lock}, {7'b0, got.lock});
        check({tag, " err"}, {7'b0, err}, {7'b0, got.err});
        check({tag, " err_cnt"}, err_cnt, got.cnt);
    endtask

    task automatic clean_bit(input logic xl, input logic c, input string tag);
        logic b;
        gen_bit(b);
        if (c) mm = 0;
        step(1'b1, b, c, mk(xl, 1'b0, xc(mm)), tag);
    endtask

    task automatic bad_bit(input logic xl, input logic c, input string tag);
        logic b;
        gen_bit(b);
        mm = c ? 1 : mm + 1;
        step(1'b1, ~b, c, mk(xl, 1'b1, xc(mm)), tag);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        #1;
        check({tag, " lock"}, {7'b0, lock}, 8'h00);
        check({tag, " err"}, {7'b0, err}, 8'h00);
        check({tag, " err_cnt"}, err_cnt, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        g   = 7'h00;
        mm  = 0;
        run = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        mm    = 0;
        run   = 0;
        g     = 7'h00;
        rst   = 1'b1;
        en    = 1'b0;
        d     = 1'b0;
        clr   = 1'b0;

        // Reset state
        #12;
        check("reset lock", {7'b0, lock}, 8'h00);
        check("reset err", {7'b0, err}, 8'h00);
        check("reset err_cnt", err_cnt, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Clean stream seeded from 7'h00: lock after the 15th accepted bit
        for (int i = 1; i <= 15; i++) clean_bit(i >= 15, 1'b0, $sformatf("s1_bit%0d", i));

        // Single inverted bit while locked
        bad_bit(1'b1, 1'b0, "s2_flip");
        clean_bit(1'b1, 1'b0, "s2_after");

        // Clear, then four consecutive errors lose lock; relock after 15 more bits
        clean_bit(1'b1, 1'b1, "s3_clr");
        for (int i = 1; i <= 4; i++) bad_bit(i < 4, 1'b0, $sformatf("s3_miss%0d", i));
        for (int i = 1; i <= 15; i++) clean_bit(i >= 15, 1'b0, $sformatf("s3_relock%0d", i));

        // Lockup seed of all ones is rejected, twice
        pulse_reset("s4_rst");
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, mk(1'b0, 1'b0, xc(0)), $sformatf("s4_ones%0d", i));
        for (int i = 1; i <= 15; i++) clean_bit(i >= 15, 1'b0, $sformatf("s4_lock%0d", i));

        // 300 isolated errors saturate the counter, then clear with a same-cycle error
        for (int i = 0; i < 300; i++) begin
            bad_bit(1'b1, 1'b0, $sformatf("s5_bad%0d", i));
            clean_bit(1'b1, 1'b0, $sformatf("s5_good%0d", i));
        end
        bad_bit(1'b1, 1'b1, "s5_clr_err");
        clean_bit(1'b1, 1'b0, "s5_after");

        // Random EN gaps: lock timing counts accepted bits only
        pulse_reset("s6_rst");
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                run++;
                clean_bit(run >= 15, 1'b0, $sformatf("s6_on%0d", i));
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0, mk(run >= 15, 1'b0, xc(mm)),
                     $sformatf("s6_off%0d", i));
            end
        end
        while (run < 16) begin
            run++;
            clean_bit(run >= 15, 1'b0, $sformatf("s6_fill%0d", run));
        end

        // Asynchronous reset mid-lock, then fresh seed and relock
        @(negedge clk);
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check("s7_async lock", {7'b0, lock}, 8'h00);
        check("s7_async err", {7'b0, err}, 8'h00);
        check("s7_async err_cnt", err_cnt, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        g   = 7'h00;
        mm  = 0;
        for (int i = 1; i <= 15; i++) clean_bit(i >= 15, 1'b0, $sformatf("s7_relock%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
PRBS7_CHECKER -- requirements
Module: prbs7_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 8: consecutive matching bits required in VERIFY before lock.
REQ-002 SHALL have parameter LOSS_CNT, default 4: consecutive mismatches in LOCKED that cause loss of lock.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port EN  input  1  serial bit valid; D is sampled only when EN=1.
REQ-006 SHALL have port D  input  1  received serial PRBS7 bit.
REQ-007 SHALL have port CLR  input  1  synchronous clear of ERR_CNT.
REQ-008 SHALL have port LOCK  output  1  registered; 1 while in LOCKED.
REQ-009 SHALL have port ERR  output  1  registered one-cycle pulse per mismatch counted in LOCKED.
REQ-010 SHALL have port ERR_CNT  output  8  saturating mismatch count.

Function
REQ-011 SHALL check the XNOR-form PRBS7 sequence (x^7+x^6+1): predicted bit = XNOR(SR[6], SR[5]); shift SR <= {SR[5:0], bit}.
REQ-012 SHALL implement three states: SEED, VERIFY and LOCKED.
REQ-013 In SEED, SHALL shift each accepted D into SR. After 7 accepted bits, SHALL go to VERIFY, unless SR = 7'h7F (XNOR lockup), in which case it SHALL restart seeding with the bit count at 0.
REQ-014 In VERIFY, SHALL compare each accepted D with the predicted bit and shift the predicted bit into SR.
REQ-015 In VERIFY, LOCK_CNT consecutive matches SHALL move the block to LOCKED; any mismatch SHALL return it to SEED with the seed count cleared.
REQ-016 In LOCKED, SHALL shift the predicted bit into SR (free-running reference). A single received error SHALL therefore produce exactly one ERR pulse.
REQ-017 In LOCKED, each mismatch SHALL assert ERR on the next cycle, increment ERR_CNT and increment a consecutive-miss counter; a match SHALL clear the consecutive-miss counter.
REQ-018 When the consecutive-miss counter reaches LOSS_CNT, SHALL enter SEED and deassert LOCK on the next cycle; that LOSS_CNT-th mismatch SHALL still be counted.
REQ-019 LOCK SHALL rise the cycle after the LOCK_CNT-th matching bit is accepted.
REQ-020 With EN=0, SHALL hold all state, SR and counters, and ERR SHALL be 0.
REQ-021 ERR_CNT SHALL saturate at 8'hFF.
REQ-022 CLR=1 SHALL set ERR_CNT to 0 on the next edge; if a counted mismatch occurs in the same cycle, ERR_CNT SHALL be 1 (the clear applies first).
REQ-023 Mismatches in SEED or VERIFY SHALL NOT assert ERR or change ERR_CNT.

Reset
REQ-024 RST=1 SHALL immediately force: state SEED, SR=0, seed, match and miss counters 0, LOCK=0, ERR=0, ERR_CNT=0.
REQ-025 Reset asserted mid-lock SHALL drop LOCK asynchronously; after release, the first accepted bit SHALL begin a fresh seed.

Configuration
REQ-026 Macro PRBS7_ERR_CNT_EN SHALL control the error counter.
REQ-027 With PRBS7_ERR_CNT_EN defined, ERR_CNT and CLR SHALL behave as in REQ-017, REQ-021 and REQ-022.
REQ-028 Without PRBS7_ERR_CNT_EN, the ERR_CNT port SHALL still exist but be tied to 8'h00, CLR SHALL be ignored, and ERR and LOCK behaviour SHALL be unchanged.

Verification
REQ-029 SHALL cover: reset, then EN=1 with an error-free PRBS7 stream seeded 7'h00 -> LOCK=1 exactly 15 accepted bits after the first, ERR never 1, ERR_CNT=0.
REQ-030 SHALL cover: locked, then one bit inverted -> exactly one ERR pulse on the following cycle, ERR_CNT=1, LOCK stays 1.
REQ-031 SHALL cover: locked, then 4 consecutive inverted bits -> ERR_CNT=4, LOCK=0 the cycle after the 4th; the clean stream then relocks after 15 more bits.
REQ-032 SHALL cover: seed bits all 1 (7'h7F) -> stays in SEED, no LOCK until a valid seed plus 8 matches.
REQ-033 SHALL cover: 300 forced mismatches while kept locked (miss counter broken by matches) -> ERR_CNT=8'hFF; then CLR together with a mismatch -> ERR_CNT=1.
REQ-034 SHALL cover: EN toggled 0/1 randomly on a clean stream -> lock timing counted in accepted bits only; RST pulsed mid-lock -> LOCK=0 immediately.
